sha1_padder: RTL and testbench

SHA1_PADDER -- requirements
Module: sha1_padder

---
 rtl/sha1_pkg.sv | 30 +++
 rtl/sha1_pad_word.sv | 32 +++
 rtl/sha1_padder.sv | 193 +++++++++++++++++++
 tb/tb_sha1_padder.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha1_pkg.sv
// Shared definitions for the SHA-1 message padder.
//   state_t      : padder FSM states
//   BLOCK_W      : width of one SHA-1 message block
//   PAD_BYTE     : the single '1' bit that terminates a message, as a byte
//   word_lsb()   : bit position of word k inside a block (word 0 is the MSW)
package sha1_pkg;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    HOLD      = 2'd1,
    EXTRA     = 2'd2,
    HOLD_LAST = 2'd3
  } state_t;

  localparam int          BLOCK_W      = 512;
  localparam int          WORDS        = BLOCK_W / 32;
  localparam logic [7:0]  PAD_BYTE     = 8'h80;
  localparam logic [31:0] PAD_WORD     = {PAD_BYTE, 24'h0};
  localparam int          LEN_HI_IDX   = 14;
  localparam int          LEN_LO_IDX   = 15;
  // Last word index that still leaves room for the 64-bit length field.
  localparam int          LAST_PAD_IDX = 13;
  localparam logic [3:0]  LAST_WIDX    = 4'd15;

  // Word k occupies [511-32k : 480-32k].
  function automatic int word_lsb(input int k);
    return BLOCK_W - 32 - 32 * k;
  endfunction

endpackage

// File: rtl/sha1_pad_word.sv
// Combinational terminator for the final word of a message.
//   data     : input word, byte 0 in [31:24], valid bytes left-justified
//   nbytes   : valid byte count, already clamped to 0..4
//   last     : this is the final word of the message
//   word     : invalid bytes zeroed, 0x80 in the first invalid byte
//   pad_next : word was full, so 0x80 belongs in byte 0 of the next word
module sha1_pad_word
  import sha1_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  nbytes,
  input  logic        last,
  output logic [31:0] word,
  output logic        pad_next
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    word     = data;
    pad_next = 1'b0;
    if (last) begin
      case (nbytes)
        3'd0:    word = {PAD_BYTE, 24'h0};
        3'd1:    word = {data[31:24], PAD_BYTE, 16'h0};
        3'd2:    word = {data[31:16], PAD_BYTE, 8'h0};
        3'd3:    word = {data[31:8], PAD_BYTE};
        default: pad_next = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/sha1_padder.sv
// SHA-1 message padder: packs 32-bit words into 512-bit blocks, appends the
// 0x80 terminator, zero fill and the 64-bit big-endian bit length.
//   clk, reset_n          : clock, asynchronous active-low reset
//   in_data/in_nbytes     : message word and its valid byte count (0..4)
//   in_last/in_valid      : final word marker, word present
//   in_ready              : a word is accepted this cycle (FILL only)
//   blk_data/blk_last     : padded block, final block of the message
//   blk_valid/blk_ready   : block handshake toward the hash core
//   err                   : sticky, an illegal byte count was seen
module sha1_padder
  import sha1_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        in_data,
  input  logic [2:0]         in_nbytes,
  input  logic               in_last,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [BLOCK_W-1:0] blk_data,
  output logic               blk_last,
  output logic               blk_valid,
  input  logic               blk_ready,
  output logic               err
);

  state_t             state_q, state_d;
  logic [3:0]         widx_q, widx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [BLOCK_W-1:0] blk_q, blk_d;
  logic               bv_q, bv_d, bl_q, bl_d;
  logic               rdy_q, rdy_d;
  logic               err_q, err_d;
  // pend: the message ended but its length did not fit, an EXTRA block follows.
  // padded: the 0x80 terminator already went out in the previous block.
  logic               pend_q, pend_d, padded_q, padded_d;

  logic               in_fire, blk_fire, illegal;
  logic [2:0]         eff_nbytes;
  logic [LEN_W-1:0]   new_len;
  logic [63:0]        len_fill, len_extra;
  logic [31:0]        pad_word;
  logic               pad_next, fits;
  int                 w_idx, p_idx;

  assign in_fire    = in_valid && rdy_q;
  assign blk_fire   = bv_q && blk_ready;
  // Anything above 4, or a short word that is not the last one, counts as 4.
  assign illegal    = (in_nbytes > 3'd4) || (!in_last && in_nbytes != 3'd4);
  assign eff_nbytes = illegal ? 3'd4 : in_nbytes;
  assign new_len    = len_q + LEN_W'({eff_nbytes, 3'b000});
  assign len_fill   = 64'(new_len);
  assign len_extra  = 64'(len_q);

  sha1_pad_word u_pad_word (
    .data     (in_data),
    .nbytes   (eff_nbytes),
    .last     (in_last),
    .word     (pad_word),
    .pad_next (pad_next)
  );

  // p_idx is the word that receives 0x80; 16 means it spills into a new block.
  assign w_idx = int'(widx_q);
  assign p_idx = w_idx + int'(pad_next);
  assign fits  = (p_idx <= LAST_PAD_IDX);

  always_comb begin
    state_d  = state_q;
    widx_d   = widx_q;
    len_d    = len_q;
    blk_d    = blk_q;
    bv_d     = bv_q;
    bl_d     = bl_q;
    err_d    = err_q;
    pend_d   = pend_q;
    padded_d = padded_q;

    case (state_q)
      FILL: begin
        if (in_fire) begin
          err_d  = err_q | illegal;
          len_d  = new_len;
          widx_d = widx_q + 4'd1;
          if (!in_last) begin
            blk_d[word_lsb(w_idx) +: 32] = in_data;
            if (widx_q == LAST_WIDX) begin
              state_d = HOLD;
              widx_d  = '0;
              bv_d    = 1'b1;
              bl_d    = 1'b0;
            end
          end else begin
            widx_d = '0;
            bv_d   = 1'b1;
            for (int k = 0; k < WORDS; k++) begin
              if (k == w_idx) begin
                blk_d[word_lsb(k) +: 32] = pad_word;
              end else if (k > w_idx) begin
                if (pad_next && k == w_idx + 1)
                  blk_d[word_lsb(k) +: 32] = PAD_WORD;
                else if (fits && k == LEN_HI_IDX)
                  blk_d[word_lsb(k) +: 32] = len_fill[63:32];
                else if (fits && k == LEN_LO_IDX)
                  blk_d[word_lsb(k) +: 32] = len_fill[31:0];
                else
                  blk_d[word_lsb(k) +: 32] = '0;
              end
            end
            if (fits) begin
              state_d = HOLD_LAST;
              bl_d    = 1'b1;
            end else begin
              state_d  = HOLD;
              bl_d     = 1'b0;
              pend_d   = 1'b1;
              padded_d = (p_idx < WORDS);
            end
          end
        end
      end

      HOLD: begin
        if (blk_fire) begin
          bv_d    = 1'b0;
          state_d = pend_q ? EXTRA : FILL;
        end
      end

      EXTRA: begin
        blk_d = '0;
        blk_d[word_lsb(LEN_HI_IDX) +: 32] = len_extra[63:32];
        blk_d[word_lsb(LEN_LO_IDX) +: 32] = len_extra[31:0];
        if (!padded_q) blk_d[word_lsb(0) +: 32] = PAD_WORD;
        bv_d    = 1'b1;
        bl_d    = 1'b1;
        state_d = HOLD_LAST;
      end

      HOLD_LAST: begin
        if (blk_fire) begin
          bv_d     = 1'b0;
          bl_d     = 1'b0;
          len_d    = '0;
          pend_d   = 1'b0;
          padded_d = 1'b0;
          state_d  = FILL;
        end
      end

      default: state_d = FILL;
    endcase

    rdy_d = (state_d == FILL);
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the block register is reset too, so no stale data survives reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= FILL;
      widx_q   <= '0;
      len_q    <= '0;
      blk_q    <= '0;
      bv_q     <= 1'b0;
      bl_q     <= 1'b0;
      rdy_q    <= 1'b0;
      err_q    <= 1'b0;
      pend_q   <= 1'b0;
      padded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      widx_q   <= widx_d;
      len_q    <= len_d;
      blk_q    <= blk_d;
      bv_q     <= bv_d;
      bl_q     <= bl_d;
      rdy_q    <= rdy_d;
      err_q    <= err_d;
      pend_q   <= pend_d;
      padded_q <= padded_d;
    end
  end

  assign in_ready  = rdy_q;
  assign blk_data  = blk_q;
  assign blk_last  = bl_q;
  assign blk_valid = bv_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sha1_padder.sv
// Self-checking bench for sha1_padder: a byte-level padding model feeds a
// block scoreboard; a vector table covers message lengths around the block
// boundaries, followed by stall, reset and error sequences.
module tb_sha1_padder;

  localparam int LEN_W = 64;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [31:0]  in_data;
  logic [2:0]   in_nbytes;
  logic         in_last;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] blk_data;
  logic         blk_last;
  logic         blk_valid;
  logic         blk_ready;
  logic         err;

  sha1_padder #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_nbytes (in_nbytes),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .blk_data  (blk_data),
    .blk_last  (blk_last),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] data;
    logic         last;
  } blk_t;

  typedef struct {
    int          len;
    logic [7:0]  seed;
    int          exp_blocks;
    bit          chk_w0;
    logic [31:0] exp_w0;
    logic [31:0] exp_w15;
  } vec_t;

  blk_t        sb[$];
  blk_t        mon_e;
  logic [7:0]  msg_q[$];
  vec_t        vecs[10];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          blk_count = 0;
  logic [31:0] last_w0, last_w15;
  bit          bp_en = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: a handshake seen at the negedge completes next posedge.
  always @(negedge clk) begin
    if (reset_n && blk_valid && blk_ready) begin
      blk_count++;
      if (blk_last) begin
        last_w0  = blk_data[511:480];
        last_w15 = blk_data[31:0];
      end
      if (sb.size() == 0) begin
        check("unexpected_block", 512'(1), 512'(0));
      end else begin
        mon_e = sb.pop_front();
        check("blk_data", blk_data, mon_e.data);
        check("blk_last", 512'(blk_last), 512'(mon_e.last));
      end
    end
  end

  // Random downstream backpressure, active only while bp_en is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) blk_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Reference padding of msg_q, done on bytes independently of the word path.
  task automatic push_expected();
    logic [7:0]  p[$];
    logic [63:0] bitlen;
    blk_t        e;
    int          nb;
    p = msg_q;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bitlen = 64'(msg_q.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bitlen[8*i +: 8]);
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      e.data = '0;
      for (int j = 0; j < 64; j++) e.data[511-8*j -: 8] = p[64*b + j];
      e.last = (b == nb - 1);
      sb.push_back(e);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input logic last);
    int t = 0;
    in_data   = d;
    in_nbytes = nb;
    in_last   = last;
    in_valid  = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 300) begin
        check("in_ready_timeout", 512'(0), 512'(1));
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Invalid bytes carry 0xEE so masking is exercised.
  task automatic send_msg();
    int n  = msg_q.size();
    int nw = (n == 0) ? 1 : (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      logic [31:0] d;
      int          nb;
      nb = (w == nw - 1) ? n - 4 * w : 4;
      for (int b = 0; b < 4; b++) d[31-8*b -: 8] = (b < nb) ? msg_q[4*w + b] : 8'hEE;
      send_word(d, 3'(nb), w == nw - 1);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 600) begin
      @(negedge clk);
      t++;
    end
    check("drain", 512'(sb.size()), 512'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic make_msg(input int len, input logic [7:0] seed);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'(seed + 8'(i)));
  endtask

  initial begin
    logic [511:0] snap;
    int           bc0;
    int           t;

    vecs[0] = '{3,   8'h61, 1, 1'b1, 32'h61626380, 32'h00000018};
    vecs[1] = '{0,   8'h00, 1, 1'b1, 32'h80000000, 32'h00000000};
    vecs[2] = '{55,  8'h10, 1, 1'b0, 32'h0,        32'h000001B8};
    vecs[3] = '{56,  8'h20, 2, 1'b1, 32'h0,        32'h000001C0};
    vecs[4] = '{64,  8'h30, 2, 1'b1, 32'h80000000, 32'h00000200};
    vecs[5] = '{60,  8'h40, 2, 1'b1, 32'h0,        32'h000001E0};
    vecs[6] = '{52,  8'h50, 1, 1'b0, 32'h0,        32'h000001A0};
    vecs[7] = '{4,   8'hA0, 1, 1'b0, 32'h0,        32'h00000020};
    vecs[8] = '{100, 8'h01, 2, 1'b0, 32'h0,        32'h00000320};
    vecs[9] = '{120, 8'h77, 3, 1'b1, 32'h0,        32'h000003C0};

    // Reset state
    reset_n   = 1'b0;
    in_data   = '0;
    in_nbytes = '0;
    in_last   = 1'b0;
    in_valid  = 1'b0;
    blk_ready = 1'b1;
    #3;
    check("rst_in_ready",  512'(in_ready),  512'(0));
    check("rst_blk_valid", 512'(blk_valid), 512'(0));
    check("rst_blk_last",  512'(blk_last),  512'(0));
    check("rst_blk_data",  blk_data,        512'(0));
    check("rst_err",       512'(err),       512'(0));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("in_ready_before_edge", 512'(in_ready), 512'(0));
    @(posedge clk);
    #1;
    check("in_ready_after_edge", 512'(in_ready), 512'(1));

    // Vector table with random backpressure
    bp_en = 1'b1;
    for (int v = 0; v < 10; v++) begin
      bc0 = blk_count;
      make_msg(vecs[v].len, vecs[v].seed);
      push_expected();
      send_msg();
      wait_drain();
      check($sformatf("nblocks_len%0d", vecs[v].len), 512'(blk_count - bc0), 512'(vecs[v].exp_blocks));
      if (vecs[v].chk_w0)
        check($sformatf("last_w0_len%0d", vecs[v].len), 512'(last_w0), 512'(vecs[v].exp_w0));
      check($sformatf("last_w15_len%0d", vecs[v].len), 512'(last_w15), 512'(vecs[v].exp_w15));
    end
    bp_en = 1'b0;
    blk_ready = 1'b1;

    // Stall: block held 10 cycles must not move and input stays blocked
    blk_ready = 1'b0;
    make_msg(3, 8'h61);
    push_expected();
    send_msg();
    t = 0;
    while (!blk_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("stall_blk_valid_rise", 512'(blk_valid), 512'(1));
    snap = blk_data;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_data_stable", blk_data, snap);
      check("stall_in_ready",    512'(in_ready),  512'(0));
      check("stall_blk_valid",   512'(blk_valid), 512'(1));
    end
    @(posedge clk);
    #1;
    blk_ready = 1'b1;
    wait_drain();

    // Reset mid-FILL: partial block discarded, next message hashes cleanly
    send_word(32'h11111111, 3'd4, 1'b0);
    send_word(32'h22222222, 3'd4, 1'b0);
    send_word(32'h33333333, 3'd4, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_in_ready",  512'(in_ready),  512'(0));
    check("midrst_blk_valid", 512'(blk_valid), 512'(0));
    check("midrst_blk_data",  blk_data,        512'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    bc0 = blk_count;
    make_msg(3, 8'h61);
    push_expected();
    send_msg();
    wait_drain();
    check("postrst_nblocks", 512'(blk_count - bc0), 512'(1));
    check("postrst_w0",      512'(last_w0),  512'(32'h61626380));
    check("postrst_w15",     512'(last_w15), 512'(32'h00000018));

    // Short non-last word: err set, word counted as 4 bytes
    check("err_clear", 512'(err), 512'(0));
    msg_q.delete();
    msg_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
    push_expected();
    send_word(32'hDEADBEEF, 3'd2, 1'b0);
    check("err_set", 512'(err), 512'(1));
    send_word(32'h01020304, 3'd4, 1'b1);
    wait_drain();
    check("err_len_w15", 512'(last_w15), 512'(32'h00000040));
    make_msg(0, 8'h00);
    push_expected();
    send_msg();
    wait_drain();
    check("err_sticky", 512'(err), 512'(1));
    reset_n = 1'b0;
    #1;
    check("err_reset", 512'(err), 512'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // in_nbytes above 4 on a last word: err, processed as a full word
    msg_q.delete();
    msg_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    push_expected();
    send_word(32'h11223344, 3'd7, 1'b1);
    check("err_nb7", 512'(err), 512'(1));
    wait_drain();
    check("nb7_w15", 512'(last_w15), 512'(32'h00000020));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
